// File: rtl/count_tx_ctrl.sv
// count_tx_ctrl: sends a snapshot of the 16-bit counter to the UART as
// four uppercase hex characters, optionally followed by CR/LF.
module count_tx_ctrl #(
  parameter bit AUTO_SEND = 1'b0,
  parameter bit SEND_CRLF = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] count,
  input  logic        send,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_load,
  output logic        busy,
  output logic        frame_done,
  output logic [2:0]  char_idx
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT_ACK,
    WAIT_DONE
  } state_t;

  localparam logic [2:0] LAST_IDX = SEND_CRLF ? 3'd5 : 3'd3;

  state_t      state_q, state_d;
  logic [15:0] snap_q, snap_d;
  logic [15:0] last_q, last_d;
  logic        pend_q, pend_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_load_q, tx_load_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  char_sel;
  logic        auto_trig;
  logic        trigger;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  always_comb begin
    char_sel = 8'h00;
    unique case (idx_q)
      3'd0:    char_sel = hex_char(snap_q[15:12]);
      3'd1:    char_sel = hex_char(snap_q[11:8]);
      3'd2:    char_sel = hex_char(snap_q[7:4]);
      3'd3:    char_sel = hex_char(snap_q[3:0]);
      3'd4:    char_sel = 8'h0D;
      3'd5:    char_sel = 8'h0A;
      default: char_sel = 8'h00;
    endcase
  end

  // pending, send and auto all capture the same live count
  assign auto_trig = AUTO_SEND && (count != last_q);
  assign trigger   = pend_q || send || auto_trig;

  always_comb begin
    state_d   = state_q;
    snap_d    = snap_q;
    last_d    = last_q;
    pend_d    = pend_q;
    tx_data_d = tx_data_q;
    tx_load_d = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    idx_d     = idx_q;

    if (send && busy_q) begin
      pend_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (trigger) begin
          snap_d  = count;
          busy_d  = 1'b1;
          idx_d   = 3'd0;
          pend_d  = 1'b0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (tx_ready) begin
          tx_data_d = char_sel;
          tx_load_d = 1'b1;
          state_d   = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (!tx_ready) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (tx_ready) begin
          if (idx_q == LAST_IDX) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            last_d  = snap_q;
            idx_d   = 3'd0;
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      snap_q    <= 16'h0000;
      last_q    <= 16'h0000;
      pend_q    <= 1'b0;
      tx_data_q <= 8'h00;
      tx_load_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      idx_q     <= 3'd0;
    end else begin
      state_q   <= state_d;
      snap_q    <= snap_d;
      last_q    <= last_d;
      pend_q    <= pend_d;
      tx_data_q <= tx_data_d;
      tx_load_q <= tx_load_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      idx_q     <= idx_d;
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_load    = tx_load_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign char_idx   = idx_q;

endmodule

// File: tb/tb_count_tx_ctrl.sv
// tb_count_tx_ctrl: directed bench for count_tx_ctrl, default build plus
// an AUTO_SEND=1 / SEND_CRLF=0 build, each with a simple UART responder.
module tb_count_tx_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] count = 16'h0000;
  logic        send = 1'b0;
  logic        tx_ready = 1'b1;
  logic [7:0]  tx_data;
  logic        tx_load;
  logic        busy;
  logic        frame_done;
  logic [2:0]  char_idx;

  logic [15:0] count_b = 16'h0000;
  logic        send_b = 1'b0;
  logic        tx_ready_b = 1'b1;
  logic [7:0]  tx_data_b;
  logic        tx_load_b;
  logic        busy_b;
  logic        frame_done_b;
  logic [2:0]  char_idx_b;

  int n_cmp = 0;
  int n_fail = 0;

  logic [7:0] qa[$];
  logic [7:0] qb[$];
  int a_done = 0;
  int b_done = 0;
  int a_busy_err = 0;
  int a_cnt = 0;
  int b_cnt = 0;
  int b_max_idx = 0;
  bit a_hold = 1'b0;
  logic a_busy_prev = 1'b0;

  count_tx_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .count      (count),
    .send       (send),
    .tx_ready   (tx_ready),
    .tx_data    (tx_data),
    .tx_load    (tx_load),
    .busy       (busy),
    .frame_done (frame_done),
    .char_idx   (char_idx)
  );

  count_tx_ctrl #(
    .AUTO_SEND (1'b1),
    .SEND_CRLF (1'b0)
  ) dut_b (
    .clk        (clk),
    .reset      (reset),
    .count      (count_b),
    .send       (send_b),
    .tx_ready   (tx_ready_b),
    .tx_data    (tx_data_b),
    .tx_load    (tx_load_b),
    .busy       (busy_b),
    .frame_done (frame_done_b),
    .char_idx   (char_idx_b)
  );

  always #5 clk = ~clk;

  // UART model A: goes busy after each load for ~10 cycles
  always @(negedge clk) begin
    if (tx_load) begin
      qa.push_back(tx_data);
      a_cnt = 11;
    end
    if (frame_done) a_done++;
    if (a_busy_prev && !busy && !frame_done) a_busy_err++;
    if (frame_done && busy) a_busy_err++;
    a_busy_prev = busy;
    if (a_hold) begin
      tx_ready = 1'b0;
    end else if (a_cnt > 0) begin
      tx_ready = 1'b0;
      a_cnt--;
    end else begin
      tx_ready = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (tx_load_b) begin
      qb.push_back(tx_data_b);
      b_cnt = 11;
    end
    if (frame_done_b) b_done++;
    if (int'(char_idx_b) > b_max_idx) b_max_idx = int'(char_idx_b);
    if (b_cnt > 0) begin
      tx_ready_b = 1'b0;
      b_cnt--;
    end else begin
      tx_ready_b = 1'b1;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_send();
    send = 1'b1;
    step();
    send = 1'b0;
  endtask

  task automatic wait_a_done(input int target, input int budget,
                             output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (a_done >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_b_done(input int target, input int budget,
                             output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (b_done >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_qa(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (qa.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idx(input logic [2:0] v, input int budget,
                          output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (char_idx == v) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    n_cmp++;
    if (tx_data !== 8'h00) begin
      n_fail++;
      $display("FAIL rst_tx_data: got %h want 00", tx_data);
    end
    n_cmp++;
    if ({tx_load, busy, frame_done} !== 3'b000) begin
      n_fail++;
      $display("FAIL rst_flags: got %b want 000",
               {tx_load, busy, frame_done});
    end
    n_cmp++;
    if (char_idx !== 3'd0) begin
      n_fail++;
      $display("FAIL rst_idx: got %0d want 0", char_idx);
    end
    reset = 1'b0;
    repeat (5) step();
    n_cmp++;
    if ({tx_load, busy, tx_load_b, busy_b} !== 4'b0000) begin
      n_fail++;
      $display("FAIL idle_after_rst: got %b want 0000",
               {tx_load, busy, tx_load_b, busy_b});
    end
  endtask

  task automatic test_basic_frame();
    logic [7:0] exp[6] = '{8'h31, 8'h41, 8'h33, 8'h46, 8'h0D, 8'h0A};
    int d0;
    int e0;
    bit ok;
    qa.delete();
    d0 = a_done;
    e0 = a_busy_err;
    count = 16'h1A3F;
    pulse_send();
    n_cmp++;
    if ({tx_load, busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL lat_n1: got load,busy=%b want 01", {tx_load, busy});
    end
    step();
    n_cmp++;
    if (tx_load !== 1'b1 || tx_data !== 8'h31) begin
      n_fail++;
      $display("FAIL lat_n2: got load=%b data=%h want 1 31",
               tx_load, tx_data);
    end
    wait_a_done(d0 + 1, 400, ok);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL basic_timeout: got no frame_done want one");
    end
    repeat (10) step();
    n_cmp++;
    if (qa.size() != 6) begin
      n_fail++;
      $display("FAIL basic_len: got %0d want 6", qa.size());
    end
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (i >= qa.size() || qa[i] !== exp[i]) begin
        n_fail++;
        $display("FAIL basic_byte%0d: got %h want %h", i,
                 (i < qa.size()) ? qa[i] : 8'hxx, exp[i]);
      end
    end
    n_cmp++;
    if (a_done - d0 != 1) begin
      n_fail++;
      $display("FAIL basic_done_cnt: got %0d want 1", a_done - d0);
    end
    n_cmp++;
    if (a_busy_err != e0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_busy: got err=%0d busy=%b want 0 0",
               a_busy_err - e0, busy);
    end
  endtask

  task automatic test_snapshot_hold();
    logic [7:0] exp[6] = '{8'h31, 8'h41, 8'h33, 8'h46, 8'h0D, 8'h0A};
    int d0;
    bit ok;
    qa.delete();
    d0 = a_done;
    count = 16'h1A3F;
    pulse_send();
    wait_qa(2, 100, ok);
    count = 16'h0002;
    wait_a_done(d0 + 1, 400, ok);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL hold_timeout: got no frame_done want one");
    end
    repeat (10) step();
    n_cmp++;
    if (qa.size() != 6) begin
      n_fail++;
      $display("FAIL hold_len: got %0d want 6", qa.size());
    end
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (i >= qa.size() || qa[i] !== exp[i]) begin
        n_fail++;
        $display("FAIL hold_byte%0d: got %h want %h", i,
                 (i < qa.size()) ? qa[i] : 8'hxx, exp[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp[12] = '{8'h30, 8'h30, 8'h46, 8'h46, 8'h0D, 8'h0A,
                            8'h42, 8'h45, 8'h45, 8'h46, 8'h0D, 8'h0A};
    int d0;
    bit ok;
    qa.delete();
    d0 = a_done;
    count = 16'h00FF;
    pulse_send();
    wait_qa(1, 100, ok);
    count = 16'hBEEF;
    pulse_send();
    repeat (5) step();
    pulse_send();
    wait_a_done(d0 + 2, 800, ok);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL b2b_timeout: got %0d frames want 2", a_done - d0);
    end
    repeat (60) step();
    n_cmp++;
    if (qa.size() != 12 || a_done - d0 != 2) begin
      n_fail++;
      $display("FAIL b2b_len: got %0d bytes %0d frames want 12 2",
               qa.size(), a_done - d0);
    end
    for (int i = 0; i < 12; i++) begin
      n_cmp++;
      if (i >= qa.size() || qa[i] !== exp[i]) begin
        n_fail++;
        $display("FAIL b2b_byte%0d: got %h want %h", i,
                 (i < qa.size()) ? qa[i] : 8'hxx, exp[i]);
      end
    end
  endtask

  task automatic test_ready_stall();
    int d0;
    bit ok;
    qa.delete();
    d0 = a_done;
    a_hold = 1'b1;
    step();
    count = 16'h5C07;
    pulse_send();
    repeat (50) step();
    n_cmp++;
    if (qa.size() != 0 || tx_load !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_load: got %0d loads want 0", qa.size());
    end
    n_cmp++;
    if (busy !== 1'b1 || char_idx !== 3'd0) begin
      n_fail++;
      $display("FAIL stall_state: got busy=%b idx=%0d want 1 0",
               busy, char_idx);
    end
    a_hold = 1'b0;
    step();
    n_cmp++;
    if (tx_ready !== 1'b1 || tx_load !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_rise: got ready=%b load=%b want 1 0",
               tx_ready, tx_load);
    end
    step();
    n_cmp++;
    if (tx_load !== 1'b1 || tx_data !== 8'h35) begin
      n_fail++;
      $display("FAIL stall_first: got load=%b data=%h want 1 35",
               tx_load, tx_data);
    end
    wait_a_done(d0 + 1, 400, ok);
    repeat (10) step();
    n_cmp++;
    if (!ok || qa.size() != 6) begin
      n_fail++;
      $display("FAIL stall_len: got %0d bytes want 6", qa.size());
    end
  endtask

  task automatic test_reset_midframe();
    int n0;
    int d0;
    bit ok;
    qa.delete();
    count = 16'h9ABC;
    pulse_send();
    wait_idx(3'd2, 200, ok);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL rmid_idx: got idx=%0d want 2", char_idx);
    end
    pulse_send();
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({tx_data, tx_load, busy, frame_done, char_idx} !== 14'h0) begin
      n_fail++;
      $display("FAIL rmid_outs: got data=%h load=%b busy=%b idx=%0d want 0",
               tx_data, tx_load, busy, char_idx);
    end
    step();
    reset = 1'b0;
    n0 = qa.size();
    repeat (60) step();
    n_cmp++;
    if (qa.size() != n0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_quiet: got %0d new loads busy=%b want 0 0",
               qa.size() - n0, busy);
    end
    qa.delete();
    d0 = a_done;
    pulse_send();
    wait_a_done(d0 + 1, 400, ok);
    repeat (10) step();
    n_cmp++;
    if (!ok || qa.size() != 6 || qa[0] !== 8'h39 || qa[5] !== 8'h0A) begin
      n_fail++;
      $display("FAIL rmid_resend: got %0d bytes first=%h want 6 39",
               qa.size(), (qa.size() > 0) ? qa[0] : 8'hxx);
    end
  endtask

  task automatic test_auto_wrap();
    int d0;
    bit ok;
    qb.delete();
    d0 = b_done;
    b_max_idx = 0;
    count_b = 16'hFFFF;
    wait_b_done(d0 + 1, 300, ok);
    repeat (3) step();
    n_cmp++;
    if (!ok || qb.size() != 4) begin
      n_fail++;
      $display("FAIL auto_ffff_len: got %0d want 4", qb.size());
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (i >= qb.size() || qb[i] !== 8'h46) begin
        n_fail++;
        $display("FAIL auto_ffff_byte%0d: got %h want 46", i,
                 (i < qb.size()) ? qb[i] : 8'hxx);
      end
    end
    count_b = 16'h0000;
    wait_b_done(d0 + 2, 300, ok);
    repeat (60) step();
    n_cmp++;
    if (!ok || qb.size() != 8 || b_done - d0 != 2) begin
      n_fail++;
      $display("FAIL auto_wrap_len: got %0d bytes %0d frames want 8 2",
               qb.size(), b_done - d0);
    end
    for (int i = 4; i < 8; i++) begin
      n_cmp++;
      if (i >= qb.size() || qb[i] !== 8'h30) begin
        n_fail++;
        $display("FAIL auto_wrap_byte%0d: got %h want 30", i,
                 (i < qb.size()) ? qb[i] : 8'hxx);
      end
    end
    n_cmp++;
    if (b_max_idx != 3) begin
      n_fail++;
      $display("FAIL auto_max_idx: got %0d want 3", b_max_idx);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_snapshot_hold();
    test_back_to_back();
    test_ready_stall();
    test_reset_midframe();
    test_auto_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of run want finish");
    $fatal(1);
  end

endmodule

// File: doc/count_tx_ctrl.md
Name: count_tx_ctrl

Overview:
Sequences transmission of the 16-bit up/down counter value through the byte-wide UART transmitter. On a request, it snapshots the count and converts it to four uppercase ASCII hex characters, MSB nibble first, optionally followed by CR/LF. It feeds the characters one at a time over a load/ready handshake. It sits between the counter, the pushbutton/auto trigger and the UART TX block.

Parameters:
AUTO_SEND, 0, 1 = start a frame automatically whenever count differs from the last transmitted snapshot while idle.
SEND_CRLF, 1, 1 = append 0x0D then 0x0A after the 4 hex characters; 0 = 4-character frame.

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
count  input  16  live counter value
send  input  1  one-cycle transmit request (already edge-detected)
tx_ready  input  1  UART TX idle / able to accept a byte
tx_data  output  8  ASCII byte presented to UART; registered
tx_load  output  1  one-cycle strobe: UART latches tx_data
busy  output  1  high from frame start until the last byte is accepted and the UART returns idle
frame_done  output  1  one-cycle pulse when a frame completes
char_idx  output  3  index of the current character (0..5)

Behaviour:
- Reset is asynchronous, active-high; clock is clk. Reset values: tx_data=0x00, tx_load=0, busy=0, frame_done=0, char_idx=0. Snapshot=0, last_sent=0, pending=0, state=IDLE.
- FSM states: IDLE, LOAD, WAIT_ACK, WAIT_DONE.
- IDLE: a trigger captures count into snapshot, sets busy=1 and char_idx=0, and moves to LOAD next cycle. A trigger is send=1, or pending=1, or (AUTO_SEND=1 and count!=last_sent). Priority: pending, then send, then auto. All three capture the same snapshot.
- LOAD: wait for tx_ready=1. On tx_ready=1, drive tx_data=char(char_idx), pulse tx_load for exactly one cycle, then go to WAIT_ACK. With tx_ready=0, remain in LOAD and do not pulse tx_load.
- WAIT_ACK: wait for tx_ready=0, which confirms the UART accepted the byte, then go to WAIT_DONE. There is no timeout.
- WAIT_DONE: wait for tx_ready=1. If char_idx is the last character (3, or 5 with SEND_CRLF=1):
  - pulse frame_done;
  - clear busy;
  - set last_sent=snapshot;
  - reset char_idx to 0;
  - go to IDLE.
  Otherwise increment char_idx and go to LOAD.
- Character map:
  - idx0 = snapshot[15:12], idx1 = [11:8], idx2 = [7:4], idx3 = [3:0].
  - Nibble n<10 maps to 0x30+n; n>=10 maps to 0x37+n ('A'..'F').
  - idx4=0x0D, idx5=0x0A.
- Snapshot holds for the whole frame. Changes on count mid-frame do not alter transmitted bytes.
- send=1 while busy=1 sets pending. Only one request is queued; further sends while pending=1 are dropped. Pending is serviced in the IDLE cycle after frame_done, using the count value at that time.
- send arriving in the same cycle as frame_done sets pending.
- Minimum latency: send at cycle N produces tx_load at cycle N+2 if tx_ready=1.
- tx_data holds its last value between loads.
- Reset mid-frame aborts immediately. The partial frame is not resumed, and pending is cleared.
- Count wrap (0xFFFF to 0x0000) is an ordinary value change. It triggers an auto frame when AUTO_SEND=1.

Test Plan:
- count=0x1A3F, send pulse, UART model drops tx_ready 1 cycle after load and raises it 10 cycles later -> bytes 0x31,0x41,0x33,0x46,0x0D,0x0A, one tx_load each; frame_done pulses once; busy falls with frame_done.
- Same frame, count changed to 0x0002 after the second byte -> remaining bytes still 0x33,0x46,0x0D,0x0A.
- Frame from 0x00FF; send pulsed twice mid-frame while count=0xBEEF -> exactly one extra frame "BEEF\r\n"; the second mid-frame send is dropped.
- tx_ready held 0 for 50 cycles at frame start -> no tx_load and state stays LOAD; first tx_load follows tx_ready rising.
- Reset asserted during char_idx=2 -> all outputs return to reset values that cycle; no further tx_load until a new send.
- AUTO_SEND=1, SEND_CRLF=0: count 0xFFFF sent, then count steps up to 0x0000 -> frame 0x30,0x30,0x30,0x30 with no CR/LF; count held constant afterwards -> no further frames.
